spi_flash_reader: RTL and testbench

Autonomous SPI-flash read engine that sits directly upstream of the `spi` controller and drives its 8-bit register port. It turns a single request (chip select, flash byte address, length) into the full command sequence: READ opcode, address bytes, then dummy bytes. Each received byte is delivered on a valid/ready byte stream. It is used for boot-time code fetch and bulk loads without CPU involvement. Integration muxes its register-port outputs with the CPU's; `busy` indicates that this block owns the port.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_flash_reader.sv | 169 ++++++++++++++++
 tb/tb_spi_flash_reader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI flash read engine: FSM state encoding and
// register addresses of the downstream spi controller.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_WAIT,
    ST_CAPT,
    ST_HOLD,
    ST_END
  } state_t;

  localparam logic [2:0] SPI_REG_DATA0 = 3'd0;
  localparam logic [2:0] SPI_REG_DATA1 = 3'd1;
  localparam logic [2:0] SPI_REG_READY = 3'd2;
  localparam logic [2:0] SPI_REG_INT   = 3'd3;
  localparam logic [2:0] SPI_REG_CFG   = 3'd4;

endpackage

// File: rtl/spi_flash_reader.sv
// Autonomous SPI-flash read engine: issues READ opcode, address and dummy
// bytes through the spi controller register port and streams received bytes.
module spi_flash_reader
  import spi_pkg::*;
#(
  parameter logic [7:0]  CMD        = 8'h03,
  parameter int unsigned ADDR_BYTES = 3,
  parameter int unsigned LEN_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_sel,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len_m1,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             done,
  output logic             busy,
  output logic [2:0]       spi_reg_addr,
  output logic [7:0]       spi_reg_data_in,
  output logic [1:0]       spi_reg_sel,
  output logic             spi_reg_read,
  output logic             spi_reg_write,
  input  logic [7:0]       spi_reg_data_out,
  input  logic             spi_interrupt
);

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           r_next;
  logic [1:0]       r_ai;
  logic [LEN_W-1:0] r_cnt;
  logic [1:0]       r_sel;
  logic [31:0]      r_addr;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_out_last;
  logic             r_done;

  logic             w_accept;
  logic             w_hs;
  logic             w_wr;
  logic             w_rd;
  logic [2:0]       w_addr;
  logic [7:0]       w_data;
  logic [7:0]       w_addr_byte;

  assign w_accept    = req_valid & req_ready;
  assign w_hs        = r_out_valid & out_ready;
  assign w_addr_byte = r_addr[{r_ai, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    w_addr      = '0;
    w_data      = '0;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_CMD;
      ST_CMD: begin
        w_wr        = 1'b1;
        w_addr      = SPI_REG_DATA0;
        w_data      = CMD;
        w_state_nxt = ST_WAIT;
      end
      ST_ADDR: begin
        w_wr        = 1'b1;
        w_addr      = SPI_REG_DATA1;
        w_data      = w_addr_byte;
        w_state_nxt = ST_WAIT;
      end
      ST_DUMMY: begin
        w_wr        = 1'b1;
        w_addr      = SPI_REG_DATA1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (spi_interrupt) w_state_nxt = r_next;
      ST_CAPT: begin
        w_rd        = 1'b1;
        w_addr      = SPI_REG_DATA1;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_hs) w_state_nxt = (r_cnt == '0) ? ST_END : ST_DUMMY;
      end
      ST_END: begin
        w_rd        = 1'b1;
        w_addr      = SPI_REG_DATA0;
        w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_next      <= ST_IDLE;
      r_ai        <= '0;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_addr      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sel  <= req_sel;
            r_addr <= req_addr;
            r_cnt  <= req_len_m1;
          end
        end
        ST_CMD: begin
          r_next <= ST_ADDR;
          r_ai   <= 2'(ADDR_BYTES - 1);
        end
        ST_ADDR: begin
          if (r_ai != 2'd0) begin
            r_next <= ST_ADDR;
            r_ai   <= r_ai - 2'd1;
          end else begin
            r_next <= ST_DUMMY;
          end
        end
        ST_DUMMY: r_next <= ST_CAPT;
        ST_CAPT: begin
          r_out_data  <= spi_reg_data_out;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_cnt == '0);
        end
        ST_HOLD: begin
          // counter only steps on handshake, so len_m1 all-ones never wraps
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_cnt != '0) r_cnt <= r_cnt - LEN_W'(1);
          end
        end
        ST_END:  r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign req_ready       = (r_state == ST_IDLE) & ~reset;
  assign busy            = (r_state != ST_IDLE);
  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign out_last        = r_out_last;
  assign done            = r_done;
  assign spi_reg_sel     = r_sel;
  assign spi_reg_write   = w_wr & ~reset;
  assign spi_reg_read    = w_rd & ~reset;
  assign spi_reg_addr    = reset ? 3'd0 : w_addr;
  assign spi_reg_data_in = reset ? 8'd0 : w_data;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench: two readers (3- and 4-byte addressing) each driving a
// behavioural spi controller + flash model; expected port ops and bytes are queued.
module tb_spi_flash_reader;

  logic        clk;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [1:0]  req_sel   [2];
  logic [31:0] req_addr  [2];
  logic [7:0]  req_len   [2];
  logic        out_valid [2];
  logic [7:0]  out_data  [2];
  logic        out_last  [2];
  logic        out_ready [2];
  logic        done      [2];
  logic        busy      [2];
  logic [2:0]  ra        [2];
  logic [7:0]  rdi       [2];
  logic [1:0]  rsel      [2];
  logic        rrd       [2];
  logic        rwr       [2];
  logic [7:0]  rdo       [2];
  logic        irq       [2];

  int          m_cnt [2];
  int          m_nb  [2];
  logic        m_cs  [2];
  logic [31:0] m_fa  [2];
  logic [7:0]  m_rx  [2];

  int          checks = 0;
  int          errors = 0;
  logic [12:0] opq  [$];
  logic [9:0]  outq [$];
  logic [1:0]  cur_sel  [2];
  int          done_cnt [2];
  int          exp_done [2];
  int          pend     [2];
  logic        held     [2];
  logic [8:0]  held_v   [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_flash_reader #(.CMD(8'h03), .ADDR_BYTES(3), .LEN_W(8)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_sel(req_sel[0]),
    .req_addr(req_addr[0]), .req_len_m1(req_len[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_last(out_last[0]),
    .out_ready(out_ready[0]), .done(done[0]), .busy(busy[0]),
    .spi_reg_addr(ra[0]), .spi_reg_data_in(rdi[0]), .spi_reg_sel(rsel[0]),
    .spi_reg_read(rrd[0]), .spi_reg_write(rwr[0]),
    .spi_reg_data_out(rdo[0]), .spi_interrupt(irq[0]));

  spi_flash_reader #(.CMD(8'h03), .ADDR_BYTES(4), .LEN_W(8)) u_dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_sel(req_sel[1]),
    .req_addr(req_addr[1]), .req_len_m1(req_len[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_last(out_last[1]),
    .out_ready(out_ready[1]), .done(done[1]), .busy(busy[1]),
    .spi_reg_addr(ra[1]), .spi_reg_data_in(rdi[1]), .spi_reg_sel(rsel[1]),
    .spi_reg_read(rrd[1]), .spi_reg_write(rwr[1]),
    .spi_reg_data_out(rdo[1]), .spi_interrupt(irq[1]));

  function automatic logic [7:0] flash_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Controller + flash model: opcode, address bytes MSB first, then each
  // dummy byte returns the next sequential flash byte.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        irq[g] <= 1'b0; m_cnt[g] <= 0; m_cs[g] <= 1'b0;
        m_nb[g] <= 0; m_fa[g] <= '0; m_rx[g] <= '0;
      end else begin
        if (rwr[g]) begin
          irq[g]   <= 1'b0;
          m_cnt[g] <= (g == 0) ? 3 : 2;
          if (ra[g] == 3'd0) begin
            m_cs[g] <= 1'b1; m_nb[g] <= 1; m_fa[g] <= '0;
          end else begin
            if (m_nb[g] <= ((g == 0) ? 3 : 4)) m_fa[g] <= {m_fa[g][23:0], rdi[g]};
            else m_rx[g] <= flash_byte(m_fa[g] + 32'(m_nb[g] - ((g == 0) ? 3 : 4) - 1));
            m_nb[g] <= m_nb[g] + 1;
          end
        end else if (m_cnt[g] != 0) begin
          m_cnt[g] <= m_cnt[g] - 1;
          if (m_cnt[g] == 1) irq[g] <= 1'b1;
        end
        if (rrd[g] && ra[g] == 3'd0) m_cs[g] <= 1'b0;
      end
    end
  end

  assign rdo[0] = (ra[0] == 3'd1) ? m_rx[0] : 8'h00;
  assign rdo[1] = (ra[1] == 3'd1) ? m_rx[1] : 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      for (int g = 0; g < 2; g++) begin pend[g] = 0; held[g] = 1'b0; end
    end else begin
      for (int g = 0; g < 2; g++) begin
        logic [12:0] e_op;
        logic [9:0]  e_out;
        if (pend[g] == 1) chk("resume_write", {31'b0, rwr[g]}, 32'd1);
        else if (pend[g] == 2) chk("end_read", {31'b0, rrd[g] && ra[g] == 3'd0}, 32'd1);
        pend[g] = 0;
        if (busy[g]) begin
          chk("pulse_excl", {31'b0, rwr[g] & rrd[g]}, 32'd0);
          chk("sel_hold", {30'b0, rsel[g]}, {30'b0, cur_sel[g]});
        end
        if (rwr[g] || rrd[g]) begin
          chk("op_while_valid", {31'b0, out_valid[g]}, 32'd0);
          if (!(rwr[g] && ra[g] == 3'd0)) chk("cs_active", {31'b0, m_cs[g]}, 32'd1);
          if (opq.size() == 0) chk("op_unexpected", 32'(opq.size()), 32'd1);
          else begin
            e_op = opq.pop_front();
            chk("port_op", {19'b0, g[0], rrd[g], ra[g], rrd[g] ? 8'h00 : rdi[g]}, {19'b0, e_op});
          end
        end else begin
          chk("idle_bus", {21'b0, ra[g], rdi[g]}, 32'd0);
        end
        if (out_valid[g] && out_ready[g]) begin
          if (outq.size() == 0) chk("out_unexpected", 32'(outq.size()), 32'd1);
          else begin
            e_out = outq.pop_front();
            chk("out_byte", {22'b0, g[0], out_last[g], out_data[g]}, {22'b0, e_out});
          end
          pend[g] = out_last[g] ? 2 : 1;
        end
        if (out_valid[g] && !out_ready[g]) begin
          if (held[g]) chk("hold_stable", {23'b0, out_last[g], out_data[g]}, {23'b0, held_v[g]});
          held[g]   = 1'b1;
          held_v[g] = {out_last[g], out_data[g]};
        end else begin
          held[g] = 1'b0;
        end
        if (done[g]) done_cnt[g]++;
      end
    end
  end

  task automatic push_req(input int g, input logic [1:0] sel, input logic [31:0] addr,
                          input logic [7:0] len_m1);
    int ab;
    logic [31:0] a;
    logic [31:0] t;
    ab = (g == 0) ? 3 : 4;
    a  = (g == 0) ? (addr & 32'h00FF_FFFF) : addr;
    opq.push_back({g[0], 1'b0, 3'd0, 8'h03});
    for (int i = ab - 1; i >= 0; i--) begin
      t = addr >> (8 * i);
      opq.push_back({g[0], 1'b0, 3'd1, t[7:0]});
    end
    for (int i = 0; i <= int'(len_m1); i++) begin
      opq.push_back({g[0], 1'b0, 3'd1, 8'h00});
      opq.push_back({g[0], 1'b1, 3'd1, 8'h00});
      outq.push_back({g[0], i == int'(len_m1), flash_byte(a + 32'(i))});
    end
    opq.push_back({g[0], 1'b1, 3'd0, 8'h00});
    cur_sel[g] = sel;
    exp_done[g]++;
  endtask

  task automatic send(input int g, input logic [1:0] sel, input logic [31:0] addr,
                      input logic [7:0] len_m1);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    req_sel[g] = sel; req_addr[g] = addr; req_len[g] = len_m1; req_valid[g] = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (req_ready[g]) ok = 1'b1;
      @(negedge clk);
    end
    req_valid[g] = 1'b0;
    chk("req_accept", {31'b0, ok}, 32'd1);
    chk("cmd_latency", {28'b0, rwr[g], ra[g]}, {28'b0, 1'b1, 3'd0});
  endtask

  task automatic wait_done(input int g, input int budget);
    for (int k = 0; k < budget && done_cnt[g] != exp_done[g]; k++) @(negedge clk);
    chk("done_count", 32'(done_cnt[g]), 32'(exp_done[g]));
    @(negedge clk);
    chk("done_single", 32'(done_cnt[g]), 32'(exp_done[g]));
    chk("cs_released", {31'b0, m_cs[g]}, 32'd0);
    chk("busy_clear", {31'b0, busy[g]}, 32'd0);
    chk("opq_drained", 32'(opq.size()), 32'd0);
    chk("outq_drained", 32'(outq.size()), 32'd0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0; req_sel[g] = '0; req_addr[g] = '0; req_len[g] = '0;
      out_ready[g] = 1'b1; cur_sel[g] = '0; done_cnt[g] = 0; exp_done[g] = 0;
      pend[g] = 0; held[g] = 1'b0; held_v[g] = '0;
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_req_ready", {31'b0, req_ready[g]}, 32'd0);
      chk("rst_outs", {27'b0, busy[g], out_valid[g], done[g], rwr[g], rrd[g]}, 32'd0);
      chk("rst_port", {19'b0, ra[g], rdi[g], rsel[g]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready0", {31'b0, req_ready[0]}, 32'd1);
    chk("post_rst_ready1", {31'b0, req_ready[1]}, 32'd1);

    // basic 4-byte read
    push_req(0, 2'd1, 32'h0001_2345, 8'd3);
    send(0, 2'd1, 32'h0001_2345, 8'd3);
    wait_done(0, 500);

    // consumer stall after first byte, with a competing request while busy
    out_ready[0] = 1'b0;
    push_req(0, 2'd0, 32'h00AB_CDEF, 8'd2);
    send(0, 2'd0, 32'h00AB_CDEF, 8'd2);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (out_valid[0]) seen = 1'b1; else @(negedge clk);
    end
    chk("first_byte_seen", {31'b0, seen}, 32'd1);
    req_sel[0] = 2'd2; req_addr[0] = 32'h0000_0055; req_len[0] = 8'd7; req_valid[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("busy_req_ready", {31'b0, req_ready[0]}, 32'd0);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    wait_done(0, 500);

    // maximum length, address window crossing a byte boundary
    push_req(0, 2'd2, 32'h00FF_FFF0, 8'd255);
    send(0, 2'd2, 32'h00FF_FFF0, 8'd255);
    wait_done(0, 5000);

    // reset during the first dummy byte, then a fresh request
    push_req(0, 2'd1, 32'h0000_0100, 8'd5);
    send(0, 2'd1, 32'h0000_0100, 8'd5);
    repeat (22) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy[0]}, 32'd0);
    chk("midrst_valid", {31'b0, out_valid[0]}, 32'd0);
    chk("midrst_pulses", {30'b0, rwr[0], rrd[0]}, 32'd0);
    chk("midrst_cs", {31'b0, m_cs[0]}, 32'd0);
    opq.delete();
    outq.delete();
    exp_done[0]--;
    reset = 1'b0;
    @(negedge clk);
    push_req(0, 2'd0, 32'h0000_0777, 8'd1);
    send(0, 2'd0, 32'h0000_0777, 8'd1);
    wait_done(0, 500);

    // 4-byte addressing, no-CS select
    push_req(1, 2'd3, 32'h89AB_CDEF, 8'd2);
    send(1, 2'd3, 32'h89AB_CDEF, 8'd2);
    wait_done(1, 500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
